channel_histogram: RTL

- Downstream consumer of the single-channel pixel extractor.
- Accumulates a 256-bin histogram of the selected 8-bit channel over one frame, bounded by frame_start/frame_end strobes.
- After frame_end, streams the bins out in index order over a valid/ready interface to the statistics and auto-threshold logic.
- Bins are cleared on read-out, so consecutive frames need no separate clear pass.

---
 rtl/channel_histogram_pkg.sv | 16 +
 rtl/channel_histogram_if.sv | 26 ++
 rtl/channel_histogram_ram.sv | 28 ++
 rtl/channel_histogram.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/channel_histogram_pkg.sv
// Shared definitions for the channel histogram: pixel width, bin count and
// the controller state encoding.
package channel_histogram_pkg;

    localparam int PIX_W    = 8;
    localparam int NUM_BINS = 256;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_READOUT
    } hist_state_t;

endpackage

// File: rtl/channel_histogram_if.sv
// Bin read-out stream: one bin (index + count) per valid/ready handshake.
interface channel_histogram_if #(
    parameter int CNT_W = 20
);
    import channel_histogram_pkg::*;

    logic [PIX_W-1:0] bin_out_index;
    logic [CNT_W-1:0] bin_out_count;
    logic             bin_out_valid;
    logic             bin_out_ready;

    modport master (
        output bin_out_index,
        output bin_out_count,
        output bin_out_valid,
        input  bin_out_ready
    );

    modport slave (
        input  bin_out_index,
        input  bin_out_count,
        input  bin_out_valid,
        output bin_out_ready
    );

endinterface

// File: rtl/channel_histogram_ram.sv
// Bin storage: simple dual-port RAM, one write port and one registered read port.
// A read of the address being written returns the old contents.
module hist_ram
    import channel_histogram_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PIX_W-1:0] wr_addr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [PIX_W-1:0] rd_addr,
    output logic [CNT_W-1:0] rd_data
);

    logic [CNT_W-1:0] mem_q [NUM_BINS];
    logic [CNT_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/channel_histogram.sv
// Per-frame 256-bin histogram of one 8-bit channel, streamed out after frame_end
// and cleared bin by bin as each one is accepted.
module channel_histogram
    import channel_histogram_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PIX_W-1:0]    pixel_in,
    input  logic                pixel_valid,
    input  logic                frame_start,
    input  logic                frame_end,
    channel_histogram_if.master bin_if,
    output logic                busy,
    output logic                overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [PIX_W-1:0] IDX_MAX = {PIX_W{1'b1}};

    hist_state_t      state_q, state_d;
    logic [PIX_W-1:0] clr_addr_q, clr_addr_d;
    logic [PIX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             s1_valid_q, s1_valid_d;
    logic [PIX_W-1:0] s1_bin_q, s1_bin_d;
    logic             fwd_valid_q, fwd_valid_d;
    logic [PIX_W-1:0] fwd_bin_q, fwd_bin_d;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
    logic             pend_q, pend_d;
    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_index_q, out_index_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;

    logic             wr_en;
    logic [PIX_W-1:0] wr_addr;
    logic [CNT_W-1:0] wr_data;
    logic [PIX_W-1:0] rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             accept;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] incr;
    logic             sat;

    hist_ram #(.CNT_W(CNT_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        rd_ptr_d    = rd_ptr_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_count_d = out_count_q;
        overflow_d  = overflow_q;
        fwd_valid_d = 1'b0;
        fwd_bin_d   = s1_bin_q;
        fwd_cnt_d   = fwd_cnt_q;
        s1_bin_d    = pixel_in;
        rd_addr     = pixel_in;

        // The RAM still holds the old count for a bin written last cycle,
        // so the just-written value is taken from the forwarding register.
        base   = (fwd_valid_q && (fwd_bin_q == s1_bin_q)) ? fwd_cnt_q : rd_data;
        sat    = (base == CNT_MAX);
        incr   = sat ? base : base + CNT_W'(1);
        accept = pixel_valid &&
                 (((state_q == ST_IDLE) && frame_start) || (state_q == ST_ACCUM));
        s1_valid_d = accept;

        wr_en   = s1_valid_q;
        wr_addr = s1_bin_q;
        wr_data = incr;
        if (s1_valid_q) begin
            fwd_valid_d = 1'b1;
            fwd_cnt_d   = incr;
            if (sat) begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            ST_CLEAR: begin
                wr_en      = 1'b1;
                wr_addr    = clr_addr_q;
                wr_data    = '0;
                clr_addr_d = clr_addr_q + PIX_W'(1);
                if (clr_addr_q == IDX_MAX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_ACCUM;
                    overflow_d = 1'b0;
                end
            end
            ST_ACCUM: begin
                if (frame_end) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q) begin
                    state_d  = ST_READOUT;
                    rd_ptr_d = '0;
                end
            end
            ST_READOUT: begin
                rd_addr = rd_ptr_q;
                if (pend_q) begin
                    out_valid_d = 1'b1;
                    out_index_d = rd_ptr_q;
                    out_count_d = rd_data;
                    pend_d      = 1'b0;
                end else if (out_valid_q) begin
                    // Accepted bin is zeroed while the next one is fetched.
                    if (bin_if.bin_out_ready) begin
                        wr_en       = 1'b1;
                        wr_addr     = out_index_q;
                        wr_data     = '0;
                        out_valid_d = 1'b0;
                        if (out_index_q == IDX_MAX) begin
                            state_d = ST_IDLE;
                        end else begin
                            rd_ptr_d = rd_ptr_q + PIX_W'(1);
                            rd_addr  = rd_ptr_q + PIX_W'(1);
                            pend_d   = 1'b1;
                        end
                    end
                end else begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            rd_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_bin_q    <= '0;
            fwd_valid_q <= 1'b0;
            fwd_bin_q   <= '0;
            fwd_cnt_q   <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_count_q <= '0;
            busy_q      <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_bin_q    <= s1_bin_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_bin_q   <= fwd_bin_d;
            fwd_cnt_q   <= fwd_cnt_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_count_q <= out_count_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bin_if.bin_out_index = out_index_q;
    assign bin_if.bin_out_count = out_count_q;
    assign bin_if.bin_out_valid = out_valid_q;
    assign busy                 = busy_q;
    assign overflow             = overflow_q;

endmodule
